// File: rtl/spi_defines.sv
// Constants shared between the SPI clock generator and the transfer sequencer,
// plus the sequencer state encoding.
package spi_defines;

  localparam int SPI_DIVIDER_LEN = 16;
  localparam int SPI_CHAR_LEN    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } xfer_state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// TX/RX shift registers for one SPI character: direction mux, MOSI bit select
// and right-justification of the received word to the active length.
module spi_shift_reg
  import spi_defines::*;
#(
  parameter int DATA_W = SPI_CHAR_LEN,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_lsb,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic [CNT_W-1:0]  i_len_eff,
  input  logic              i_rx_shift,
  input  logic              i_tx_shift,
  input  logic              i_miso,
  input  logic              i_capture,
  output logic              o_mosi,
  output logic [DATA_W-1:0] o_rx_data
);

  logic              lsb_q, lsb_d, mosi_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [DATA_W-1:0] top_bit, len_mask;
  logic [CNT_W-1:0]  top_idx;

  // Bit masks instead of variable part-selects keep index widths exact.
  assign top_idx  = i_len_eff - CNT_W'(1);
  assign top_bit  = DATA_W'(1) << top_idx;
  assign len_mask = ~({DATA_W{1'b1}} << i_len_eff);

  always_comb begin
    lsb_d = lsb_q;
    tx_d  = tx_q;
    rx_d  = rx_q;
    if (i_load) begin
      lsb_d = i_lsb;
      tx_d  = i_tx_data;
      rx_d  = '0;
    end else begin
      // LSB-first fills downward from the top active bit; bits above it stay 0.
      if (i_rx_shift)
        rx_d = lsb_q ? ((rx_q >> 1) | (DATA_W'(i_miso) << top_idx))
                     : {rx_q[DATA_W-2:0], i_miso};
      if (i_tx_shift)
        tx_d = lsb_q ? (tx_q >> 1) : (tx_q << 1);
    end
    mosi_d = lsb_d ? tx_d[0] : |(tx_d & top_bit);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lsb_q     <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      o_mosi    <= 1'b0;
      o_rx_data <= '0;
    end else begin
      lsb_q  <= lsb_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      o_mosi <= mosi_d;
      if (i_capture)
        o_rx_data <= rx_d & len_mask;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer between the register interface and spi_clk_gen.
//   state    | meaning
//   ST_IDLE  | waiting for i_go, clock generator disabled
//   ST_SHIFT | clocking bits, counting rx samples up to len_eff
//   ST_DONE  | single cycle with o_done high, then back to idle
module spi_xfer_ctrl
  import spi_defines::*;
#(
  parameter int DATA_W = SPI_CHAR_LEN,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_lsb,
  input  logic              i_tx_negedge,
  input  logic              i_rx_negedge,
  input  logic              i_ie,
  input  logic              i_irq_clr,
  input  logic              i_pos_edge,
  input  logic              i_neg_edge,
  input  logic              i_miso,
  output logic              o_enable,
  output logic              o_tx_start,
  output logic              o_last_clk,
  output logic              o_mosi,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_irq,
  output logic [DATA_W-1:0] o_rx_data
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_W);

  xfer_state_t      state_q;
  logic [CNT_W-1:0] cnt_q, len_q, len_new, len_cur, cnt_inc;
  logic             tx_neg_q, rx_neg_q;
  logic             tx_edge, rx_edge, load, in_shift, rx_shift, tx_shift, finish;

  assign len_new  = (i_len == '0 || i_len > LEN_MAX) ? LEN_MAX : i_len;
  assign load     = (state_q == ST_IDLE) && i_go && !i_abort;
  assign len_cur  = load ? len_new : len_q;

  assign tx_edge  = tx_neg_q ? i_neg_edge : i_pos_edge;
  assign rx_edge  = rx_neg_q ? i_neg_edge : i_pos_edge;
  assign in_shift = (state_q == ST_SHIFT) && !i_abort;
  assign rx_shift = in_shift && rx_edge;
  assign cnt_inc  = cnt_q + CNT_W'(rx_shift);
  // A tx edge ahead of the first sample would drop bit 0, so it is ignored.
  assign tx_shift = in_shift && tx_edge && (cnt_inc != '0);
  assign finish   = rx_shift && (cnt_inc == len_q);

  assign o_last_clk = (state_q == ST_SHIFT) && (cnt_q == len_q - CNT_W'(1));

  spi_shift_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shift (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load),
    .i_lsb      (i_lsb),
    .i_tx_data  (i_tx_data),
    .i_len_eff  (len_cur),
    .i_rx_shift (rx_shift),
    .i_tx_shift (tx_shift),
    .i_miso     (i_miso),
    .i_capture  (finish),
    .o_mosi     (o_mosi),
    .o_rx_data  (o_rx_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      tx_neg_q   <= 1'b0;
      rx_neg_q   <= 1'b0;
      o_enable   <= 1'b0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_irq      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      o_irq      <= (finish && i_ie) || (o_irq && !i_irq_clr);
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            len_q      <= len_new;
            tx_neg_q   <= i_tx_negedge;
            rx_neg_q   <= i_rx_negedge;
            cnt_q      <= '0;
            o_tx_start <= 1'b1;
            o_enable   <= 1'b1;
            o_busy     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (i_abort) begin
            o_enable <= 1'b0;
            o_busy   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_inc;
            if (finish) begin
              o_enable <= 1'b0;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
